wave_gen: RTL and testbench

- Parametrised waveform generator; successor to the fixed triangle counter that feeds the R2R+PWM DAC.
- Produces a DAC code, one update per DAC request pulse (val_req from the DAC core).
- Adds runtime-selectable mode, bounds and step size.
- Configuration is double-buffered, so changes apply only at period boundaries and never glitch the waveform.

---
 rtl/wave_gen.sv | 181 ++++++++++++++++++
 tb/tb_wave_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wave_gen.sv
// Waveform generator for the R2R+PWM DAC: SAW/TRI/SQUARE/DC, one update per val_req,
// with a double-buffered configuration that is applied only at period boundaries.
module wave_gen #(
  parameter int unsigned DAC_BITS  = 14,
  parameter int unsigned STEP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 val_req,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_mode,
  input  logic [DAC_BITS-1:0]  cfg_lo,
  input  logic [DAC_BITS-1:0]  cfg_hi,
  input  logic [STEP_BITS-1:0] cfg_step,
  output logic [DAC_BITS-1:0]  dac_val,
  output logic                 dir,
  output logic                 wrap,
  output logic                 cfg_pending
);

  localparam int unsigned SUM_BITS = DAC_BITS + 1;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_DC     = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e                mode;
    logic [DAC_BITS-1:0]  lo;
    logic [DAC_BITS-1:0]  hi;
    logic [STEP_BITS-1:0] step;
  } cfg_t;

  localparam cfg_t RST_CFG = '{
    mode: MODE_TRI,
    lo:   '0,
    hi:   '1,
    step: STEP_BITS'(1)
  };

  cfg_t                 act_q, act_d;
  cfg_t                 shd_q, shd_d;
  logic                 pend_q, pend_d;
  logic [DAC_BITS-1:0]  dac_q, dac_d;
  logic                 dir_q, dir_d;
  logic                 wrap_q, wrap_d;
  logic [STEP_BITS-1:0] hold_q, hold_d;

  logic                 apply;
  logic                 range_ok;
  logic [STEP_BITS-1:0] step_eff;
  logic [SUM_BITS-1:0]  cur_w, lo_w, hi_w, step_w, sum_w, lo_plus_w, diff_w;

  // Wide arithmetic so comparisons against the bounds never see overflow
  always_comb begin
    step_eff  = (act_q.step == '0) ? STEP_BITS'(1) : act_q.step;
    step_w    = SUM_BITS'(step_eff);
    cur_w     = SUM_BITS'(dac_q);
    lo_w      = SUM_BITS'(act_q.lo);
    hi_w      = SUM_BITS'(act_q.hi);
    sum_w     = cur_w + step_w;
    lo_plus_w = lo_w + step_w;
    diff_w    = cur_w - step_w;
    range_ok  = (act_q.lo < act_q.hi);
  end

  // Next-state logic: waveform update, apply event, shadow write
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    dac_d  = dac_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    hold_d = hold_q;
    apply  = 1'b0;

    if (!en) begin
      apply = 1'b1;
    end else if (val_req) begin
      if (!range_ok) begin
        dac_d  = act_q.lo;
        dir_d  = 1'b0;
        hold_d = '0;
      end else begin
        case (act_q.mode)
          MODE_SAW: begin
            dir_d = 1'b0;
            if (sum_w <= hi_w) begin
              dac_d = DAC_BITS'(sum_w);
            end else begin
              wrap_d = 1'b1;
              apply  = 1'b1;
            end
          end
          MODE_TRI: begin
            if (!dir_q) begin
              if (sum_w >= hi_w) begin
                dac_d = act_q.hi;
                dir_d = 1'b1;
              end else begin
                dac_d = DAC_BITS'(sum_w);
              end
            end else if (cur_w <= lo_plus_w) begin
              wrap_d = 1'b1;
              apply  = 1'b1;
            end else begin
              dac_d = DAC_BITS'(diff_w);
            end
          end
          MODE_SQUARE: begin
            if (hold_q == step_eff - STEP_BITS'(1)) begin
              hold_d = '0;
              if (!dir_q) begin
                dir_d = 1'b1;
                dac_d = act_q.hi;
              end else begin
                wrap_d = 1'b1;
                apply  = 1'b1;
              end
            end else begin
              hold_d = hold_q + STEP_BITS'(1);
            end
          end
          default: begin
            wrap_d = 1'b1;
            apply  = 1'b1;
          end
        endcase
      end
    end

    // Loading the shadow restarts the waveform at the new lower bound
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
      dac_d  = shd_q.lo;
      dir_d  = 1'b0;
      hold_d = '0;
    end

    // A write coinciding with an apply lands in the shadow after the old value moves
    if (cfg_we) begin
      shd_d.mode = mode_e'(cfg_mode);
      shd_d.lo   = cfg_lo;
      shd_d.hi   = cfg_hi;
      shd_d.step = cfg_step;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= RST_CFG;
      shd_q  <= RST_CFG;
      pend_q <= 1'b0;
      dac_q  <= '0;
      dir_q  <= 1'b0;
      wrap_q <= 1'b0;
      hold_q <= '0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      dac_q  <= dac_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      hold_q <= hold_d;
    end
  end

  assign dac_val     = dac_q;
  assign dir         = dir_q;
  assign wrap        = wrap_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_wave_gen.sv
// Directed-vector bench for wave_gen: one table entry per clock, expected values hand-computed.
module tb_wave_gen;

  localparam int unsigned DB = 14;
  localparam int unsigned SB = 8;
  localparam logic [1:0] SAW = 2'd0, TRI = 2'd1, SQR = 2'd2, DC = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, val_req = 1'b0, cfg_we = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [DB-1:0] cfg_lo = '0, cfg_hi = '0;
  logic [SB-1:0] cfg_step = '0;
  logic [DB-1:0] dac_val;
  logic          dir, wrap, cfg_pending;

  wave_gen #(.DAC_BITS(DB), .STEP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .en(en), .val_req(val_req), .cfg_we(cfg_we),
    .cfg_mode(cfg_mode), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_step(cfg_step),
    .dac_val(dac_val), .dir(dir), .wrap(wrap), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, vr, we;
    logic [1:0]    mode;
    logic [DB-1:0] lo, hi;
    logic [SB-1:0] step;
    logic [DB-1:0] e_dac;
    logic          e_dir, e_wrap, e_pend;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic e, input logic v, input logic w, input logic [1:0] m,
                              input int lo, input int hi, input int st,
                              input int d, input logic di, input logic wr, input logic p);
    vec_t x;
    x.en = e; x.vr = v; x.we = w; x.mode = m;
    x.lo = DB'(lo); x.hi = DB'(hi); x.step = SB'(st);
    x.e_dac = DB'(d); x.e_dir = di; x.e_wrap = wr; x.e_pend = p;
    return x;
  endfunction

  // Shorthands: shadow write while idle, idle cycle, run pulse, run hold
  function automatic void cfgw(input logic [1:0] m, input int lo, input int hi, input int st, input int d);
    vq.push_back(mk(1'b0, 1'b0, 1'b1, m, lo, hi, st, d, 1'b0, 1'b0, 1'b1));
  endfunction
  function automatic void idle(input int d);
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0, d, 1'b0, 1'b0, 1'b0));
  endfunction
  function automatic void pls(input int d, input logic di, input logic wr, input logic p);
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 0, d, di, wr, p));
  endfunction

  task automatic check(input string name, input logic [DB-1:0] d, input logic di,
                       input logic wr, input logic p);
    n_vec++;
    if (dac_val !== d || dir !== di || wrap !== wr || cfg_pending !== p) begin
      n_miss++;
      $display("FAIL %s: got dac=%0d dir=%0b wrap=%0b pend=%0b, want dac=%0d dir=%0b wrap=%0b pend=%0b",
               name, dac_val, dir, wrap, cfg_pending, d, di, wr, p);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    en = v.en; val_req = v.vr; cfg_we = v.we;
    cfg_mode = v.mode; cfg_lo = v.lo; cfg_hi = v.hi; cfg_step = v.step;
    @(posedge clk);
    #1;
    check(name, v.e_dac, v.e_dir, v.e_wrap, v.e_pend);
  endtask

  initial begin
    // TRI 10..14 step 1
    cfgw(TRI, 10, 14, 1, 0); idle(10);
    pls(11, 0, 0, 0); pls(12, 0, 0, 0); pls(13, 0, 0, 0);
    pls(14, 1, 0, 0); pls(13, 1, 0, 0); pls(12, 1, 0, 0); pls(11, 1, 0, 0);
    pls(10, 0, 1, 0);
    pls(11, 0, 0, 0); pls(12, 0, 0, 0); pls(13, 0, 0, 0); pls(14, 1, 0, 0);
    // SAW 0..100 step 30, then 20 cycles without requests
    cfgw(SAW, 0, 100, 30, 10); idle(0);
    pls(30, 0, 0, 0); pls(60, 0, 0, 0); pls(90, 0, 0, 0); pls(0, 0, 1, 0); pls(30, 0, 0, 0);
    for (int i = 0; i < 20; i++) vq.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 0, 30, 1'b0, 1'b0, 1'b0));
    // SQUARE 100/200 hold 3
    cfgw(SQR, 100, 200, 3, 0); idle(100);
    for (int r = 0; r < 2; r++) begin
      pls(100, 0, 0, 0); pls(100, 0, 0, 0); pls(200, 1, 0, 0);
      pls(200, 1, 0, 0); pls(200, 1, 0, 0); pls(100, 0, 1, 0);
    end
    // step=0 acts as step=1
    cfgw(SAW, 0, 10, 0, 100); idle(0);
    pls(1, 0, 0, 0); pls(2, 0, 0, 0); pls(3, 0, 0, 0);
    // lo == hi: flat, never wraps
    cfgw(TRI, 7, 7, 5, 0); idle(7);
    pls(7, 0, 0, 0); pls(7, 0, 0, 0); pls(7, 0, 0, 0);
    // SAW to full scale with step 255: no overflow
    cfgw(SAW, 0, 16383, 255, 7); idle(0);
    for (int k = 1; k <= 64; k++) pls(k * 255, 0, 0, 0);
    pls(0, 0, 1, 0); pls(255, 0, 0, 0);
    // Mid-period reconfiguration while TRI is rising
    cfgw(TRI, 10, 14, 1, 0); idle(10);
    pls(11, 0, 0, 0); pls(12, 0, 0, 0);
    vq.push_back(mk(1'b1, 1'b0, 1'b1, SAW, 0, 50, 5, 12, 1'b0, 1'b0, 1'b1));
    pls(13, 0, 0, 1); pls(14, 1, 0, 1); pls(13, 1, 0, 1); pls(12, 1, 0, 1); pls(11, 1, 0, 1);
    pls(0, 0, 1, 0); pls(5, 0, 0, 0); pls(10, 0, 0, 0);
    // DC: every request is an apply point
    cfgw(DC, 20, 30, 1, 0); idle(20);
    pls(20, 0, 1, 0); pls(20, 0, 1, 0);
    vq.push_back(mk(1'b1, 1'b0, 1'b1, DC, 25, 30, 1, 20, 1'b0, 1'b0, 1'b1));
    pls(25, 0, 1, 0);

    #2;
    check("reset_state", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i));

    // Async reset during SQUARE high phase with a pending shadow
    run_vec(mk(1'b0, 1'b0, 1'b1, SQR, 100, 200, 3, 25, 1'b0, 1'b0, 1'b1), "rst_setup0");
    run_vec(mk(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0, 100, 1'b0, 1'b0, 1'b0), "rst_setup1");
    for (int k = 0; k < 3; k++)
      run_vec(mk(1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 0, (k == 2) ? 200 : 100, k == 2, 1'b0, 1'b0),
              $sformatf("rst_sq%0d", k));
    run_vec(mk(1'b1, 1'b0, 1'b1, SAW, 33, 40, 2, 200, 1'b1, 1'b0, 1'b1), "rst_pendwr");
    @(negedge clk);
    val_req = 1'b0; cfg_we = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++)
      run_vec(mk(1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 0, k, 1'b0, 1'b0, 1'b0), $sformatf("rst_tri%0d", k));
    run_vec(mk(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0), "rst_shadow_dropped");
    run_vec(mk(1'b1, 1'b1, 1'b0, 2'd0, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0), "rst_cfg_tri");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
